syn_sram_ctrl: RTL and testbench

SYN_SRAM_CTRL -- requirements
Module: syn_sram_ctrl

---
 rtl/syn_sram_ctrl.sv | 115 +++++++++++
 tb/tb_syn_sram_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/syn_sram_ctrl.sv
// Controller for an asynchronous 16-bit SRAM: 3-cycle reads, 4-cycle writes
// (setup / we_n pulse / hold), with every SRAM strobe driven straight from a flop.
module syn_sram_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18
) (
  input  logic              clk_ir,
  input  logic              rst_ih,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rdy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              coll_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD1    = 3'd1,
    RD2    = 3'd2,
    WR_SU  = 3'd3,
    WR_PLS = 3'd4,
    WR_HLD = 3'd5
  } state_t;

  state_t              state_reg, state_next;
  logic                accept;
  logic                ce_n_reg, ce_n_next;
  logic                oe_n_reg, oe_n_next;
  logic                we_n_reg, we_n_next;
  logic                dq_oe_reg, dq_oe_next;
  logic                rd_valid_reg, rd_valid_next;
  logic                coll_err_reg, coll_err_next;
  logic [ADDR_W-1:0]   sram_addr_reg;
  logic [DATA_W-1:0]   sram_dq_o_reg;
  logic [DATA_W-1:0]   rd_data_reg;

  assign rdy    = (state_reg == IDLE);
  assign accept = rdy & (rd_en | wr_en);

  // A write wins over a simultaneous read; the read is dropped and flagged.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = wr_en ? WR_SU : RD1;
      RD1:     state_next = RD2;
      RD2:     state_next = IDLE;
      WR_SU:   state_next = WR_PLS;
      WR_PLS:  state_next = WR_HLD;
      WR_HLD:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are decoded from the upcoming state so each one lands in a flop.
  always_comb begin
    ce_n_next     = (state_next == IDLE);
    oe_n_next     = !((state_next == RD1) || (state_next == RD2));
    we_n_next     = (state_next != WR_PLS);
    dq_oe_next    = (state_next == WR_SU) || (state_next == WR_PLS) ||
                    (state_next == WR_HLD);
    rd_valid_next = (state_reg == RD2);
    coll_err_next = accept & rd_en & wr_en;
  end

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      state_reg     <= IDLE;
      ce_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
      we_n_reg      <= 1'b1;
      dq_oe_reg     <= 1'b0;
      rd_valid_reg  <= 1'b0;
      coll_err_reg  <= 1'b0;
      sram_addr_reg <= '0;
      sram_dq_o_reg <= '0;
      rd_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      ce_n_reg      <= ce_n_next;
      oe_n_reg      <= oe_n_next;
      we_n_reg      <= we_n_next;
      dq_oe_reg     <= dq_oe_next;
      rd_valid_reg  <= rd_valid_next;
      coll_err_reg  <= coll_err_next;
      if (accept) sram_addr_reg <= addr;
      if (accept && wr_en) sram_dq_o_reg <= wr_data;
      if (state_reg == RD2) rd_data_reg <= sram_dq_i;
    end
  end

  assign sram_ce_n  = ce_n_reg;
  assign sram_lb_n  = ce_n_reg;
  assign sram_ub_n  = ce_n_reg;
  assign sram_oe_n  = oe_n_reg;
  assign sram_we_n  = we_n_reg;
  assign sram_dq_oe = dq_oe_reg;
  assign sram_addr  = sram_addr_reg;
  assign sram_dq_o  = sram_dq_o_reg;
  assign rd_data    = rd_data_reg;
  assign rd_valid   = rd_valid_reg;
  assign coll_err   = coll_err_reg;

endmodule

// File: tb/tb_syn_sram_ctrl.sv
// Bench for syn_sram_ctrl: behavioural SRAM, busy-window transaction model,
// directed cases followed by random rd/wr traffic.
module tb_syn_sram_ctrl;

  logic        clk_ir = 1'b0;
  logic        rst_ih = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [17:0] addr = '0;
  logic [15:0] wr_data = '0;
  logic        rdy, rd_valid, coll_err;
  logic [15:0] rd_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i = 16'hDEAD;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  syn_sram_ctrl #(.DATA_W(16), .ADDR_W(18)) dut (
    .clk_ir(clk_ir), .rst_ih(rst_ih), .rd_en(rd_en), .wr_en(wr_en),
    .addr(addr), .wr_data(wr_data), .rdy(rdy), .rd_valid(rd_valid),
    .rd_data(rd_data), .coll_err(coll_err), .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  always #5 clk_ir = ~clk_ir;

  // Behavioural asynchronous SRAM, sampled mid-cycle.
  bit [15:0] sram_mem [int];
  always @(negedge clk_ir) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[int'(sram_addr)] = sram_dq_o;
    if (!sram_ce_n && !sram_oe_n)
      sram_dq_i = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 16'h0000;
    else
      sram_dq_i = 16'hDEAD;
  end

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a request is taken when the bus is free; a read occupies
  // 3 cycles and returns data 2 edges later, a write occupies 4 cycles.
  bit [15:0] model_mem [int];
  int        edge_n = 0, next_free = 0, rd_due = 0;
  bit        rd_pend = 0;
  bit [15:0] rd_pend_data;
  bit        exp_rdy = 1, exp_valid = 0, exp_coll = 0;
  bit [15:0] exp_rd_data = 0;
  bit        verbose = 1;
  int        reads_acc = 0, valid_cnt = 0, coll_cnt = 0, we_low_cnt = 0, rdy_low_cnt = 0;

  task automatic model_edge(input bit rd, input bit wr, input logic [17:0] a, input logic [15:0] d);
    edge_n++;
    exp_valid = 0;
    exp_coll  = 0;
    if (rd_pend && rd_due == edge_n) begin
      exp_valid   = 1;
      exp_rd_data = rd_pend_data;
      rd_pend     = 0;
    end
    if (edge_n >= next_free && (rd || wr)) begin
      if (wr) begin
        model_mem[int'(a)] = d;
        next_free = edge_n + 4;
        exp_coll  = rd;
        if (verbose) $display("txn WRITE addr=0x%05h data=0x%04h coll=%0d", a, d, rd);
      end else begin
        rd_pend      = 1;
        rd_due       = edge_n + 2;
        rd_pend_data = model_mem.exists(int'(a)) ? model_mem[int'(a)] : 16'h0000;
        next_free    = edge_n + 3;
        reads_acc++;
        if (verbose) $display("txn READ  addr=0x%05h expect=0x%04h", a, rd_pend_data);
      end
    end
    exp_rdy = (edge_n + 1 >= next_free);
  endtask

  task automatic model_reset();
    next_free   = edge_n;
    rd_pend     = 0;
    exp_rdy     = 1;
    exp_valid   = 0;
    exp_coll    = 0;
    exp_rd_data = 0;
  endtask

  task automatic step(input bit rd, input bit wr, input logic [17:0] a, input logic [15:0] d);
    rd_en = rd; wr_en = wr; addr = a; wr_data = d;
    @(posedge clk_ir);
    model_edge(rd, wr, a, d);
    @(negedge clk_ir);
    if (!sram_we_n) we_low_cnt++;
    if (rd_valid)   valid_cnt++;
    if (coll_err)   coll_cnt++;
    if (!rdy)       rdy_low_cnt++;
    check_eq("rdy", rdy, exp_rdy);
    check_eq("rd_valid", rd_valid, exp_valid);
    check_eq("rd_data", rd_data, exp_rd_data);
    check_eq("coll_err", coll_err, exp_coll);
    check_eq("contention", sram_dq_oe & ~sram_oe_n, 0);
    check_eq("lb_ub", {sram_lb_n, sram_ub_n}, {sram_ce_n, sram_ce_n});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_strobes"}, {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe}, 6'b111110);
    check_eq({tag, "_addr"}, sram_addr, 0);
    check_eq({tag, "_dq_o"}, sram_dq_o, 0);
    check_eq({tag, "_rd_data"}, rd_data, 0);
    check_eq({tag, "_pulses"}, {rd_valid, coll_err}, 0);
    check_eq({tag, "_rdy"}, rdy, 1);
  endtask

  task automatic clear_counts();
    valid_cnt = 0; coll_cnt = 0; we_low_cnt = 0; rdy_low_cnt = 0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_ir);
    check_reset_outputs("reset");
    rst_ih = 1'b0;
    model_reset();

    // Write then read back
    clear_counts();
    step(0, 1, 18'h00123, 16'hA5C3);
    repeat (3) step(0, 0, 0, 0);
    check_eq("wr_we_pulse_len", we_low_cnt, 1);
    step(1, 0, 18'h00123, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_eq("wr_rd_valid", rd_valid, 1);
    check_eq("wr_rd_data", rd_data, 16'hA5C3);
    step(0, 0, 0, 0);

    // Back-to-back reads at 0,1,2
    clear_counts();
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 18'(i / 3), 0);
      check_eq("b2b_valid_slot", rd_valid, (i % 3 == 2) ? 1 : 0);
    end
    rd_en = 0;
    check_eq("b2b_valid_cnt", valid_cnt, 3);
    check_eq("b2b_rdy_low", rdy_low_cnt, 6);
    step(0, 0, 0, 0);

    // Collision at all-ones address
    clear_counts();
    step(1, 1, 18'h3FFFF, 16'hFFFF);
    check_eq("coll_addr_ones", sram_addr, 18'h3FFFF);
    repeat (4) step(0, 0, 0, 0);
    check_eq("coll_cnt", coll_cnt, 1);
    check_eq("coll_no_valid", valid_cnt, 0);
    check_eq("coll_we_pulse", we_low_cnt, 1);
    step(1, 0, 18'h3FFFF, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_eq("coll_readback", rd_data, 16'hFFFF);
    step(0, 0, 0, 0);

    // Reset during WR_PLS (address 0x55 is outside the random range)
    step(0, 1, 18'h00055, 16'h1234);
    step(0, 0, 0, 0);
    check_eq("pls_we_low", sram_we_n, 0);
    @(posedge clk_ir);
    #2 rst_ih = 1'b1;
    #1;
    check_reset_outputs("midwr_reset");
    @(posedge clk_ir);
    @(negedge clk_ir);
    edge_n += 2;
    rst_ih = 1'b0;
    model_reset();
    check_eq("post_reset_rdy", rdy, 1);
    step(1, 0, 18'h00123, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_eq("post_reset_read", rd_data, 16'hA5C3);
    step(0, 0, 0, 0);

    // Random traffic
    verbose   = 0;
    reads_acc = 0;
    clear_counts();
    for (int i = 0; i < 10000; i++) begin
      logic [17:0] a;
      bit          r, w;
      a = ($urandom_range(0, 15) == 0) ? 18'h3FFFF : 18'($urandom_range(0, 31));
      r = ($urandom_range(0, 99) < 55);
      w = ($urandom_range(0, 99) < 40);
      step(r, w, a, 16'($urandom));
    end
    repeat (5) step(0, 0, 0, 0);
    check_eq("rand_reads_vs_valids", valid_cnt, reads_acc);
    $display("random phase: reads=%0d valids=%0d collisions=%0d", reads_acc, valid_cnt, coll_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
